multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_pkg.sv | 105 ++++++++++
 rtl/alu_decoder.sv | 27 ++
 rtl/multicycle_control.sv | 132 +++++++++++++
 tb/tb_multicycle_control.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: ALU codes, opcode and
// funct constants, FSM state encoding and the per-state Moore output table.
package ctrl_pkg;

    typedef logic [3:0] alu_code_t;

    localparam alu_code_t ALU_AND = 4'b0000;
    localparam alu_code_t ALU_OR  = 4'b0001;
    localparam alu_code_t ALU_ADD = 4'b0010;
    localparam alu_code_t ALU_SUB = 4'b0110;
    localparam alu_code_t ALU_SLT = 4'b0111;
    localparam alu_code_t ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_R   = 4'd7,
        S_WB_I   = 4'd8,
        S_WB_MEM = 4'd9,
        S_BR     = 4'd10,
        S_JMP    = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    // br marks the branch state; the actual pc_write is qualified by zero
    typedef struct packed {
        logic pc_write;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic reg_dst;
        logic alu_src;
        logic mem_to_reg;
        logic sign_ext_sel;
        logic busy;
        logic br;
    } ctrl_t;

    function automatic ctrl_t moore_outputs(input state_t s);
        ctrl_t o;
        o = '0;
        case (s)
            S_FETCH:  o.mem_read = 1'b1;
            S_DECODE: o.busy = 1'b1;
            S_EXEC_R: o.busy = 1'b1;
            S_EXEC_I, S_ADDR: begin
                o.alu_src      = 1'b1;
                o.sign_ext_sel = 1'b1;
                o.busy         = 1'b1;
            end
            S_MEM_RD: begin
                o.mem_read = 1'b1;
                o.busy     = 1'b1;
            end
            S_MEM_WR: begin
                o.mem_write = 1'b1;
                o.busy      = 1'b1;
            end
            S_WB_R: begin
                o.reg_write = 1'b1;
                o.reg_dst   = 1'b1;
                o.busy      = 1'b1;
            end
            S_WB_I: begin
                o.reg_write = 1'b1;
                o.busy      = 1'b1;
            end
            S_WB_MEM: begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = 1'b1;
                o.busy       = 1'b1;
            end
            S_BR: begin
                o.br   = 1'b1;
                o.busy = 1'b1;
            end
            S_JMP: begin
                o.pc_write = 1'b1;
                o.busy     = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct-to-ALU-code mapping for R-type instructions.
// Unknown funct values fall back to ADD and are flagged so write-back can be
// suppressed.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output alu_code_t  alu_code,
    output logic       funct_ok
);

    // Map funct to ALU operation, defaulting to ADD for unlisted codes
    always_comb begin
        alu_code = ALU_ADD;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  alu_code = ALU_ADD;
            FN_SUB:  alu_code = ALU_SUB;
            FN_AND:  alu_code = ALU_AND;
            FN_OR:   alu_code = ALU_OR;
            FN_NOR:  alu_code = ALU_NOR;
            FN_SLT:  alu_code = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit. Moore FSM whose outputs are registered
// alongside the state; only the fetch-completion pulse and the taken-branch
// pc_write are qualified by the live mem_ready / zero inputs, so the writes
// land on the edge that completes them.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN -- undefined opcodes trap into
// HALT with a sticky illegal flag instead of being treated as NOPs.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  alu_src,
    output logic                  mem_to_reg,
    output logic                  sign_ext_sel,
    output logic                  busy,
    output logic                  illegal
);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t UNDEF_NEXT = S_HALT;
`else
    localparam state_t UNDEF_NEXT = S_FETCH;
`endif

    state_t                  state, state_n;
    ctrl_t                   ctl_q, ctl_n;
    alu_code_t               dec_code, alu_n;
    logic                    funct_ok;
    logic                    fetch_ack;
    logic [ALU_CTRL_W-1:0]   alu_ctrl_q;

    alu_decoder u_alu_decoder (
        .funct    (funct),
        .alu_code (dec_code),
        .funct_ok (funct_ok)
    );

    // The first FETCH cycle after reset has mem_read low, so a stray
    // mem_ready there is not mistaken for a completed fetch.
    assign fetch_ack = (state == S_FETCH) && ctl_q.mem_read && mem_ready;

    // Next-state selection
    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:  if (fetch_ack) state_n = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_n = S_EXEC_R;
                    OP_ADDI:      state_n = S_EXEC_I;
                    OP_LW, OP_SW: state_n = S_ADDR;
                    OP_BEQ:       state_n = S_BR;
                    OP_J:         state_n = S_JMP;
                    default:      state_n = UNDEF_NEXT;
                endcase
            end
            S_EXEC_R: state_n = S_WB_R;
            S_EXEC_I: state_n = S_WB_I;
            S_ADDR:   state_n = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_n = S_WB_MEM;
            S_MEM_WR: if (mem_ready) state_n = S_FETCH;
            S_WB_R, S_WB_I, S_WB_MEM, S_BR, S_JMP: state_n = S_FETCH;
            S_HALT:   state_n = S_HALT;
            default:  state_n = S_FETCH;
        endcase
    end

    // Outputs for the state being entered, so they are ready as a register
    always_comb begin
        ctl_n = moore_outputs(state_n);
        if (state_n == S_WB_R && !funct_ok) ctl_n.reg_write = 1'b0;
        case (state_n)
            S_EXEC_R, S_WB_R: alu_n = dec_code;
            S_EXEC_I, S_ADDR: alu_n = ALU_ADD;
            S_BR:             alu_n = ALU_SUB;
            default:          alu_n = ALU_AND;
        endcase
    end

    // State and registered outputs; reset forces FETCH with everything low
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            ctl_q      <= '0;
            alu_ctrl_q <= '0;
        end else begin
            state      <= state_n;
            ctl_q      <= ctl_n;
            alu_ctrl_q <= ALU_CTRL_W'(alu_n);
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) illegal_q <= 1'b0;
        else if (state_n == S_HALT) illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign alu_ctrl     = alu_ctrl_q;
    assign pc_write     = fetch_ack | ctl_q.pc_write | (ctl_q.br & zero);
    assign ir_write     = fetch_ack;
    assign mem_read     = ctl_q.mem_read;
    assign mem_write    = ctl_q.mem_write;
    assign reg_write    = ctl_q.reg_write;
    assign reg_dst      = ctl_q.reg_dst;
    assign alu_src      = ctl_q.alu_src;
    assign mem_to_reg   = ctl_q.mem_to_reg;
    assign sign_ext_sel = ctl_q.sign_ext_sel;
    assign busy         = ctl_q.busy | fetch_ack;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-cycle vector table plus a bounded
// lw-with-wait-states sequence.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] alu_ctrl;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       reg_dst, alu_src, mem_to_reg, sign_ext_sel, busy, illegal;
    logic [9:0] ctl_bus;

    int checks   = 0;
    int failures = 0;

    multicycle_control #(.ALU_CTRL_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .alu_ctrl     (alu_ctrl),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .alu_src      (alu_src),
        .mem_to_reg   (mem_to_reg),
        .sign_ext_sel (sign_ext_sel),
        .busy         (busy),
        .illegal      (illegal)
    );

    // bit order: pc ir mr mw rw rd as mtr se busy
    assign ctl_bus = {pc_write, ir_write, mem_read, mem_write, reg_write,
                      reg_dst, alu_src, mem_to_reg, sign_ext_sel, busy};

    localparam logic [9:0] E_IDLE  = 10'b0000000000;
    localparam logic [9:0] E_FWAIT = 10'b0010000000;
    localparam logic [9:0] E_FACK  = 10'b1110000001;
    localparam logic [9:0] E_BUSY  = 10'b0000000001;
    localparam logic [9:0] E_IMM   = 10'b0000001011;
    localparam logic [9:0] E_MRD   = 10'b0010000001;
    localparam logic [9:0] E_MWR   = 10'b0001000001;
    localparam logic [9:0] E_WBR   = 10'b0000110001;
    localparam logic [9:0] E_WBRX  = 10'b0000010001;
    localparam logic [9:0] E_WBI   = 10'b0000100001;
    localparam logic [9:0] E_WBM   = 10'b0000100101;
    localparam logic [9:0] E_PCW   = 10'b1000000001;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BAD  = 6'b111111;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        logic [9:0] exp;
        logic [3:0] alu;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [9:0] exp,
                        input logic [3:0] alu, input logic ill);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
        v.exp = exp; v.alu = alu; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic rdy);
        @(negedge clk);
        reset = rst; opcode = op; funct = fn; zero = z; mem_ready = rdy;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    logic [5:0] rfn [7];
    logic [3:0] rcode [7];
    logic       rok [7];
    int         wb_cyc;
    int         mr_cnt;
    logic       rdy_v;

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

        rfn   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b100001};
        rcode = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b1100,   4'b0111,   4'b0010};
        rok   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // post-reset idle cycle: everything low, mem_ready ignored
        push(0, T_R, 6'b100000, 0, 1, E_IDLE, 4'b0000, 0);
        // R-type: FETCH, DECODE, EXEC_R, WB_R
        for (int i = 0; i < 7; i++) begin
            push(0, T_R, rfn[i], 0, 1, E_FACK, 4'b0000, 0);
            push(0, T_R, rfn[i], 0, 1, E_BUSY, 4'b0000, 0);
            push(0, T_R, rfn[i], 0, 1, E_BUSY, rcode[i], 0);
            push(0, T_R, rfn[i], 0, 1, rok[i] ? E_WBR : E_WBRX, rcode[i], 0);
        end
        // addi with a SUB funct pattern that must be ignored
        push(0, T_ADDI, 6'b100010, 0, 1, E_FACK, 4'b0000, 0);
        push(0, T_ADDI, 6'b100010, 0, 1, E_BUSY, 4'b0000, 0);
        push(0, T_ADDI, 6'b100010, 0, 1, E_IMM,  4'b0010, 0);
        push(0, T_ADDI, 6'b100010, 0, 1, E_WBI,  4'b0000, 0);
        // sw, 4 cycles
        push(0, T_SW, 6'b0, 0, 1, E_FACK, 4'b0000, 0);
        push(0, T_SW, 6'b0, 0, 1, E_BUSY, 4'b0000, 0);
        push(0, T_SW, 6'b0, 0, 1, E_IMM,  4'b0010, 0);
        push(0, T_SW, 6'b0, 0, 1, E_MWR,  4'b0000, 0);
        // lw, 5 cycles
        push(0, T_LW, 6'b0, 0, 1, E_FACK, 4'b0000, 0);
        push(0, T_LW, 6'b0, 0, 1, E_BUSY, 4'b0000, 0);
        push(0, T_LW, 6'b0, 0, 1, E_IMM,  4'b0010, 0);
        push(0, T_LW, 6'b0, 0, 1, E_MRD,  4'b0000, 0);
        push(0, T_LW, 6'b0, 0, 1, E_WBM,  4'b0000, 0);
        // beq taken after one fetch wait cycle
        push(0, T_BEQ, 6'b0, 1, 0, E_FWAIT, 4'b0000, 0);
        push(0, T_BEQ, 6'b0, 1, 1, E_FACK,  4'b0000, 0);
        push(0, T_BEQ, 6'b0, 1, 1, E_BUSY,  4'b0000, 0);
        push(0, T_BEQ, 6'b0, 1, 1, E_PCW,   4'b0110, 0);
        // beq not taken; zero high only during DECODE
        push(0, T_BEQ, 6'b0, 0, 1, E_FACK, 4'b0000, 0);
        push(0, T_BEQ, 6'b0, 1, 1, E_BUSY, 4'b0000, 0);
        push(0, T_BEQ, 6'b0, 0, 1, E_BUSY, 4'b0110, 0);
        // j, 3 cycles
        push(0, T_J, 6'b0, 0, 1, E_FACK, 4'b0000, 0);
        push(0, T_J, 6'b0, 0, 1, E_BUSY, 4'b0000, 0);
        push(0, T_J, 6'b0, 0, 1, E_PCW,  4'b0000, 0);
        // sw stalled in MEM_WR, then reset during the wait
        push(0, T_SW, 6'b0, 0, 1, E_FACK, 4'b0000, 0);
        push(0, T_SW, 6'b0, 0, 1, E_BUSY, 4'b0000, 0);
        push(0, T_SW, 6'b0, 0, 1, E_IMM,  4'b0010, 0);
        push(0, T_SW, 6'b0, 0, 0, E_MWR,  4'b0000, 0);
        push(1, T_SW, 6'b0, 0, 0, E_MWR,  4'b0000, 0);
        push(0, T_SW, 6'b0, 0, 1, E_IDLE, 4'b0000, 0);
        push(0, T_SW, 6'b0, 0, 1, E_FACK, 4'b0000, 0);
        push(0, T_SW, 6'b0, 0, 1, E_BUSY, 4'b0000, 0);
        push(0, T_SW, 6'b0, 0, 1, E_IMM,  4'b0010, 0);
        push(0, T_SW, 6'b0, 0, 1, E_MWR,  4'b0000, 0);
        // undefined opcode
        push(0, T_BAD, 6'b0, 0, 1, E_FACK, 4'b0000, 0);
        push(0, T_BAD, 6'b0, 0, 1, E_BUSY, 4'b0000, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        push(0, T_BAD, 6'b0, 0, 1, E_IDLE, 4'b0000, 1);
        push(0, T_R,   6'b0, 0, 1, E_IDLE, 4'b0000, 1);
        push(0, T_J,   6'b0, 1, 1, E_IDLE, 4'b0000, 1);
        push(1, T_R,   6'b0, 0, 1, E_IDLE, 4'b0000, 1);
        push(0, T_R,   6'b0, 0, 1, E_IDLE, 4'b0000, 0);
`else
        push(0, T_BAD, 6'b0, 0, 0, E_FWAIT, 4'b0000, 0);
        push(0, T_BAD, 6'b0, 0, 1, E_FACK,  4'b0000, 0);
        push(0, T_BAD, 6'b0, 0, 1, E_BUSY,  4'b0000, 0);
        push(0, T_BAD, 6'b0, 0, 0, E_FWAIT, 4'b0000, 0);
`endif

        drive(1, '0, '0, 0, 0);
        drive(1, '0, '0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy);
            check($sformatf("row%0d ctl", i), 32'(ctl_bus), 32'(vecs[i].exp));
            check($sformatf("row%0d alu", i), 32'(alu_ctrl), 32'(vecs[i].alu));
            check($sformatf("row%0d illegal", i), 32'(illegal), 32'(vecs[i].ill));
        end

        // lw with mem_ready low for 3 cycles inside MEM_RD
        drive(1, T_LW, '0, 0, 0);
        drive(0, T_LW, '0, 0, 0);
        wb_cyc = 0;
        mr_cnt = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            rdy_v = (cyc >= 4 && cyc <= 6) ? 1'b0 : 1'b1;
            drive(0, T_LW, '0, 0, rdy_v);
            if (cyc >= 2 && mem_read) mr_cnt++;
            if (reg_write && mem_to_reg) begin
                wb_cyc = cyc;
                break;
            end
        end
        check("lw_wait writeback cycle", 32'(wb_cyc), 32'd8);
        check("lw_wait mem_read cycles", 32'(mr_cnt), 32'd4);
        drive(0, T_LW, '0, 0, 0);
        check("lw_wait back in fetch", 32'(ctl_bus), 32'(E_FWAIT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
